// File: rtl/aludec_pipe.sv
// ALU-control decoder with an output pipeline register, a valid/ready handshake,
// flush, and an interlock that holds HI/LO-dependent ops while a mul/div is in flight.
module aludec_pipe #(
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned TRAP_EN    = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] alucontrol,
  output logic              invalid_instr,
  output logic              md_busy
);

  localparam int unsigned CODE_W = 8;
  localparam int unsigned CNT_W  = 8;

  // ALU operation codes
  localparam logic [CODE_W-1:0] EXE_NOP_OP     = 8'b0000_0000;
  localparam logic [CODE_W-1:0] EXE_AND_OP     = 8'b0010_0100;
  localparam logic [CODE_W-1:0] EXE_OR_OP      = 8'b0010_0101;
  localparam logic [CODE_W-1:0] EXE_XOR_OP     = 8'b0010_0110;
  localparam logic [CODE_W-1:0] EXE_NOR_OP     = 8'b0010_0111;
  localparam logic [CODE_W-1:0] EXE_ANDI_OP    = 8'b0101_1001;
  localparam logic [CODE_W-1:0] EXE_ORI_OP     = 8'b0101_1010;
  localparam logic [CODE_W-1:0] EXE_XORI_OP    = 8'b0101_1011;
  localparam logic [CODE_W-1:0] EXE_LUI_OP     = 8'b0101_1100;
  localparam logic [CODE_W-1:0] EXE_SLL_OP     = 8'b0111_1100;
  localparam logic [CODE_W-1:0] EXE_SLLV_OP    = 8'b0000_0100;
  localparam logic [CODE_W-1:0] EXE_SRL_OP     = 8'b0000_0010;
  localparam logic [CODE_W-1:0] EXE_SRLV_OP    = 8'b0000_0110;
  localparam logic [CODE_W-1:0] EXE_SRA_OP     = 8'b0000_0011;
  localparam logic [CODE_W-1:0] EXE_SRAV_OP    = 8'b0000_0111;
  localparam logic [CODE_W-1:0] EXE_MFHI_OP    = 8'b0001_0000;
  localparam logic [CODE_W-1:0] EXE_MTHI_OP    = 8'b0001_0001;
  localparam logic [CODE_W-1:0] EXE_MFLO_OP    = 8'b0001_0010;
  localparam logic [CODE_W-1:0] EXE_MTLO_OP    = 8'b0001_0011;
  localparam logic [CODE_W-1:0] EXE_SLT_OP     = 8'b0010_1010;
  localparam logic [CODE_W-1:0] EXE_SLTU_OP    = 8'b0010_1011;
  localparam logic [CODE_W-1:0] EXE_SLTI_OP    = 8'b0101_0111;
  localparam logic [CODE_W-1:0] EXE_SLTIU_OP   = 8'b0101_1000;
  localparam logic [CODE_W-1:0] EXE_ADD_OP     = 8'b0010_0000;
  localparam logic [CODE_W-1:0] EXE_ADDU_OP    = 8'b0010_0001;
  localparam logic [CODE_W-1:0] EXE_SUB_OP     = 8'b0010_0010;
  localparam logic [CODE_W-1:0] EXE_SUBU_OP    = 8'b0010_0011;
  localparam logic [CODE_W-1:0] EXE_ADDI_OP    = 8'b0101_0101;
  localparam logic [CODE_W-1:0] EXE_ADDIU_OP   = 8'b0101_0110;
  localparam logic [CODE_W-1:0] EXE_MULT_OP    = 8'b0001_1000;
  localparam logic [CODE_W-1:0] EXE_MULTU_OP   = 8'b0001_1001;
  localparam logic [CODE_W-1:0] EXE_DIV_OP     = 8'b0001_1010;
  localparam logic [CODE_W-1:0] EXE_DIVU_OP    = 8'b0001_1011;
  localparam logic [CODE_W-1:0] EXE_JR_OP      = 8'b0000_1000;
  localparam logic [CODE_W-1:0] EXE_JALR_OP    = 8'b0000_1001;
  localparam logic [CODE_W-1:0] EXE_SYSCALL_OP = 8'b0000_1100;
  localparam logic [CODE_W-1:0] EXE_BREAK_OP   = 8'b0000_1011;
  localparam logic [CODE_W-1:0] FUNCT_INVALID  = 8'b1111_1111;

  localparam logic [5:0] OP_SPECIAL = 6'h00;

  logic [CODE_W-1:0] dec_code;
  logic              dec_inv;
  logic              md_op;
  logic              is_mul;
  logic              hilo_dep;
  logic              accept;
  logic              transfer;

  logic              out_valid_d, out_valid_q;
  logic [CTRL_W-1:0] alucontrol_d, alucontrol_q;
  logic              invalid_d, invalid_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Combinational decode of op/funct plus mul/div and HI/LO classification
  always_comb begin
    dec_code = EXE_NOP_OP;
    dec_inv  = 1'b0;
    md_op    = 1'b0;
    is_mul   = 1'b0;
    hilo_dep = 1'b0;
    case (op)
      6'h0C: dec_code = EXE_ANDI_OP;
      6'h0D: dec_code = EXE_ORI_OP;
      6'h0E: dec_code = EXE_XORI_OP;
      6'h0F: dec_code = EXE_LUI_OP;
      6'h08: dec_code = EXE_ADDI_OP;
      6'h09: dec_code = EXE_ADDIU_OP;
      6'h0A: dec_code = EXE_SLTI_OP;
      6'h0B: dec_code = EXE_SLTIU_OP;
      OP_SPECIAL: begin
        case (funct)
          6'h24: dec_code = EXE_AND_OP;
          6'h25: dec_code = EXE_OR_OP;
          6'h26: dec_code = EXE_XOR_OP;
          6'h27: dec_code = EXE_NOR_OP;
          6'h00: dec_code = EXE_SLL_OP;
          6'h02: dec_code = EXE_SRL_OP;
          6'h03: dec_code = EXE_SRA_OP;
          6'h04: dec_code = EXE_SLLV_OP;
          6'h06: dec_code = EXE_SRLV_OP;
          6'h07: dec_code = EXE_SRAV_OP;
          6'h10: begin dec_code = EXE_MFHI_OP; hilo_dep = 1'b1; end
          6'h11: begin dec_code = EXE_MTHI_OP; hilo_dep = 1'b1; end
          6'h12: begin dec_code = EXE_MFLO_OP; hilo_dep = 1'b1; end
          6'h13: begin dec_code = EXE_MTLO_OP; hilo_dep = 1'b1; end
          6'h20: dec_code = EXE_ADD_OP;
          6'h21: dec_code = EXE_ADDU_OP;
          6'h22: dec_code = EXE_SUB_OP;
          6'h23: dec_code = EXE_SUBU_OP;
          6'h2A: dec_code = EXE_SLT_OP;
          6'h2B: dec_code = EXE_SLTU_OP;
          6'h18: begin dec_code = EXE_MULT_OP;  md_op = 1'b1; is_mul = 1'b1; hilo_dep = 1'b1; end
          6'h19: begin dec_code = EXE_MULTU_OP; md_op = 1'b1; is_mul = 1'b1; hilo_dep = 1'b1; end
          6'h1A: begin dec_code = EXE_DIV_OP;   md_op = 1'b1; hilo_dep = 1'b1; end
          6'h1B: begin dec_code = EXE_DIVU_OP;  md_op = 1'b1; hilo_dep = 1'b1; end
          6'h08: dec_code = EXE_JR_OP;
          6'h09: dec_code = EXE_JALR_OP;
          6'h0C: dec_code = EXE_SYSCALL_OP;
          6'h0D: dec_code = EXE_BREAK_OP;
          default: begin
            dec_code = FUNCT_INVALID;
            dec_inv  = (TRAP_EN != 0);
          end
        endcase
      end
      default: dec_code = EXE_NOP_OP;
    endcase
  end

  // Handshake: a HI/LO-dependent op waits while the mul/div counter is nonzero
  always_comb begin
    in_ready = resetn & ~flush & (~out_valid_q | out_ready) & ~(hilo_dep & md_busy);
    accept   = in_valid & in_ready;
    transfer = out_valid_q & out_ready;
  end

  // Next state of the output register and mul/div counter; flush overrides everything
  always_comb begin
    out_valid_d  = out_valid_q;
    alucontrol_d = alucontrol_q;
    invalid_d    = invalid_q;
    cnt_d        = cnt_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    if (flush) begin
      out_valid_d = 1'b0;
      cnt_d       = '0;
    end else begin
      if (accept) begin
        out_valid_d  = 1'b1;
        alucontrol_d = CTRL_W'(dec_code);
        invalid_d    = dec_inv;
        if (md_op) begin
          cnt_d = is_mul ? CNT_W'(MUL_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end else if (transfer) begin
        out_valid_d = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_valid_q  <= 1'b0;
      alucontrol_q <= CTRL_W'(EXE_NOP_OP);
      invalid_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      alucontrol_q <= alucontrol_d;
      invalid_q    <= invalid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign alucontrol    = alucontrol_q;
  assign invalid_instr = invalid_q;
  assign md_busy       = (cnt_q != '0);

endmodule

// File: tb/tb_aludec_pipe.sv
// Directed bench for aludec_pipe: decode table plus handshake, interlock, flush and reset sequences.
module tb_aludec_pipe;

  localparam logic [7:0] C_NOP   = 8'h00;
  localparam logic [7:0] C_AND   = 8'h24;
  localparam logic [7:0] C_NOR   = 8'h27;
  localparam logic [7:0] C_ORI   = 8'h5A;
  localparam logic [7:0] C_ANDI  = 8'h59;
  localparam logic [7:0] C_LUI   = 8'h5C;
  localparam logic [7:0] C_SLTIU = 8'h58;
  localparam logic [7:0] C_SLL   = 8'h7C;
  localparam logic [7:0] C_SRAV  = 8'h07;
  localparam logic [7:0] C_ADDU  = 8'h21;
  localparam logic [7:0] C_SUBU  = 8'h23;
  localparam logic [7:0] C_SLT   = 8'h2A;
  localparam logic [7:0] C_JALR  = 8'h09;
  localparam logic [7:0] C_BREAK = 8'h0B;
  localparam logic [7:0] C_SYSC  = 8'h0C;
  localparam logic [7:0] C_MFHI  = 8'h10;
  localparam logic [7:0] C_MFLO  = 8'h12;
  localparam logic [7:0] C_MULT  = 8'h18;
  localparam logic [7:0] C_DIV   = 8'h1A;
  localparam logic [7:0] C_INV   = 8'hFF;

  logic       clk = 1'b0;
  logic       resetn;
  logic       in_valid, flush, out_ready;
  logic [5:0] op, funct;
  logic       in_ready, out_valid, invalid_instr, md_busy;
  logic [7:0] alucontrol;
  logic       in_ready2, out_valid2, invalid_instr2, md_busy2;
  logic [7:0] alucontrol2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aludec_pipe dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .funct(funct), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alucontrol(alucontrol),
    .invalid_instr(invalid_instr), .md_busy(md_busy)
  );

  aludec_pipe #(.TRAP_EN(0)) dut_notrap (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
    .op(op), .funct(funct), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .alucontrol(alucontrol2),
    .invalid_instr(invalid_instr2), .md_busy(md_busy2)
  );

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic [7:0] ctrl;
    logic       inv;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic v, input logic [5:0] o, input logic [5:0] f);
    in_valid = v;
    op       = o;
    funct    = f;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[16];
    vecs[0]  = '{6'h0D, 6'h00, C_ORI,   1'b0};
    vecs[1]  = '{6'h0D, 6'h3F, C_ORI,   1'b0};
    vecs[2]  = '{6'h0C, 6'h15, C_ANDI,  1'b0};
    vecs[3]  = '{6'h0F, 6'h00, C_LUI,   1'b0};
    vecs[4]  = '{6'h0B, 6'h00, C_SLTIU, 1'b0};
    vecs[5]  = '{6'h00, 6'h3F, C_INV,   1'b1};
    vecs[6]  = '{6'h00, 6'h24, C_AND,   1'b0};
    vecs[7]  = '{6'h00, 6'h27, C_NOR,   1'b0};
    vecs[8]  = '{6'h00, 6'h00, C_SLL,   1'b0};
    vecs[9]  = '{6'h00, 6'h07, C_SRAV,  1'b0};
    vecs[10] = '{6'h00, 6'h2A, C_SLT,   1'b0};
    vecs[11] = '{6'h00, 6'h09, C_JALR,  1'b0};
    vecs[12] = '{6'h00, 6'h0D, C_BREAK, 1'b0};
    vecs[13] = '{6'h00, 6'h0C, C_SYSC,  1'b0};
    vecs[14] = '{6'h23, 6'h3F, C_NOP,   1'b0};
    vecs[15] = '{6'h00, 6'h01, C_INV,   1'b1};

    resetn = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = 6'h00; funct = 6'h00;
    repeat (3) @(posedge clk);
    #3 resetn = 1'b1;
    tick();

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_alucontrol", 32'(alucontrol), 32'(C_NOP));
    check("rst_invalid", 32'(invalid_instr), 32'd0);
    check("rst_md_busy", 32'(md_busy), 32'd0);

    // Back-to-back decode of the table with out_ready held high
    for (int i = 0; i < 16; i++) begin
      present(1'b1, vecs[i].op, vecs[i].funct);
      check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
      tick();
      check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("vec%0d_ctrl", i), 32'(alucontrol), 32'(vecs[i].ctrl));
      check($sformatf("vec%0d_inv", i), 32'(invalid_instr), 32'(vecs[i].inv));
      check($sformatf("vec%0d_notrap_ctrl", i), 32'(alucontrol2), 32'(vecs[i].ctrl));
      check($sformatf("vec%0d_notrap_inv", i), 32'(invalid_instr2), 32'd0);
    end
    present(1'b0, 6'h00, 6'h00);
    tick();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_ctrl_hold", 32'(alucontrol), 32'(C_INV));

    // DIV then MFLO: MFLO stalls 32 cycles
    present(1'b1, 6'h00, 6'h1A);
    check("div_in_ready", 32'(in_ready), 32'd1);
    tick();
    check("div_ctrl", 32'(alucontrol), 32'(C_DIV));
    present(1'b1, 6'h00, 6'h12);
    for (int k = 1; k <= 32; k++) begin
      check($sformatf("div_busy_T%0d", k), 32'(md_busy), 32'd1);
      check($sformatf("div_stall_T%0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    check("div_done_busy", 32'(md_busy), 32'd0);
    check("mflo_ready_T33", 32'(in_ready), 32'd1);
    tick();
    check("mflo_ctrl", 32'(alucontrol), 32'(C_MFLO));
    check("mflo_valid", 32'(out_valid), 32'd1);
    present(1'b0, 6'h00, 6'h00);
    tick();

    // MULT, ADDU flows past, MFHI waits until count reaches 0
    present(1'b1, 6'h00, 6'h18);
    tick();
    check("mult_ctrl", 32'(alucontrol), 32'(C_MULT));
    present(1'b1, 6'h00, 6'h21);
    check("addu_ready_busy", 32'(in_ready), 32'd1);
    check("addu_md_busy", 32'(md_busy), 32'd1);
    tick();
    check("addu_ctrl", 32'(alucontrol), 32'(C_ADDU));
    present(1'b1, 6'h00, 6'h10);
    for (int k = 2; k <= 4; k++) begin
      check($sformatf("mfhi_stall_T%0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    check("mfhi_ready_T5", 32'(in_ready), 32'd1);
    tick();
    check("mfhi_ctrl", 32'(alucontrol), 32'(C_MFHI));
    present(1'b0, 6'h00, 6'h00);
    tick();

    // Backpressure: SUBU held stable, then transfer plus accept in one cycle
    present(1'b1, 6'h00, 6'h23);
    tick();
    out_ready = 1'b0;
    present(1'b1, 6'h0D, 6'h00);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
      check($sformatf("bp_ctrl_%0d", k), 32'(alucontrol), 32'(C_SUBU));
      check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    check("bp_next_ctrl", 32'(alucontrol), 32'(C_ORI));
    check("bp_next_valid", 32'(out_valid), 32'd1);
    present(1'b0, 6'h00, 6'h00);
    tick();
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ctrl_hold", 32'(alucontrol), 32'(C_ORI));

    // Flush with a DIV in flight (count 20) and output held
    out_ready = 1'b0;
    present(1'b1, 6'h00, 6'h1A);
    tick();
    present(1'b0, 6'h00, 6'h00);
    repeat (12) tick();
    check("pre_flush_busy", 32'(md_busy), 32'd1);
    check("pre_flush_valid", 32'(out_valid), 32'd1);
    flush = 1'b1;
    out_ready = 1'b1;
    present(1'b1, 6'h0D, 6'h00);
    check("flush_in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    present(1'b0, 6'h00, 6'h00);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy", 32'(md_busy), 32'd0);
    check("flush_no_accept", 32'(alucontrol), 32'(C_DIV));

    // Asynchronous reset in the middle of a MFLO stall
    present(1'b1, 6'h00, 6'h1A);
    tick();
    present(1'b1, 6'h00, 6'h12);
    repeat (3) tick();
    #1 resetn = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_ctrl", 32'(alucontrol), 32'(C_NOP));
    check("arst_inv", 32'(invalid_instr), 32'd0);
    check("arst_busy", 32'(md_busy), 32'd0);
    check("arst_ready", 32'(in_ready), 32'd0);
    present(1'b0, 6'h00, 6'h00);
    @(negedge clk);
    resetn = 1'b1;
    tick();
    check("post_rst_valid", 32'(out_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
